// File: rtl/frame_rx_pkg.sv
// -----------------------------------------------------------------------------
// frame_rx_pkg
// Shared definitions for the serial frame receiver.
//   - rx_state_e       : bit-level UART receive FSM states
//   - DEF_CLKS_PER_BIT : default clocks per UART bit (115200 baud @ 125 MHz)
//   - DEF_BYTES_PER_FRAME / DEF_IDLE_TIMEOUT : default frame geometry/timeout
// The bit timing and frame size defaults are shared with the camera frame
// transmitter so both ends of the link agree.
// -----------------------------------------------------------------------------
package frame_rx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } rx_state_e;

  localparam int unsigned DEF_CLKS_PER_BIT    = 1085;
  localparam int unsigned DEF_BYTES_PER_FRAME = 9216;
  localparam int unsigned DEF_IDLE_TIMEOUT    = 62500000;

endpackage

// File: rtl/uart_rx_byte.sv
// -----------------------------------------------------------------------------
// uart_rx_byte
// 8N1 UART byte receiver: 2-FF input synchronizer, bit FSM, shift register.
// Ports:
//   clk_i      : clock
//   rst_ni     : asynchronous active-low reset
//   rx_i       : asynchronous serial input (idle high)
//   start_o    : a start-bit falling edge is accepted this cycle
//   valid_o    : one-cycle strobe, good byte on data_o (stop bit sampled high)
//   data_o     : received byte, LSB first on the line
//   stop_err_o : one-cycle strobe, stop bit sampled low (byte discarded)
//   idle_o     : FSM is in IDLE
// -----------------------------------------------------------------------------
module uart_rx_byte
  import frame_rx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       rx_i,
  output logic       start_o,
  output logic       valid_o,
  output logic [7:0] data_o,
  output logic       stop_err_o,
  output logic       idle_o
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

  logic [1:0]       sync_q;
  logic             rx_s;
  rx_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       shift_q, shift_d;
  // Set once rx_s has been seen high in IDLE; a start edge needs it, so a
  // line stuck low after a bad stop bit cannot retrigger the receiver.
  logic             armed_q, armed_d;

  assign rx_s = sync_q[1];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q  <= 2'b11;
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      armed_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], rx_i};
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      armed_q <= armed_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    shift_d    = shift_q;
    armed_d    = armed_q;
    start_o    = 1'b0;
    valid_o    = 1'b0;
    stop_err_o = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (armed_q && !rx_s) begin
          start_o = 1'b1;
          state_d = ST_START;
          cnt_d   = '0;
          armed_d = 1'b0;
        end else if (rx_s) begin
          armed_d = 1'b1;
        end
      end
      ST_START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d = '0;
          if (!rx_s) begin
            state_d = ST_DATA;
            idx_d   = '0;
          end else begin
            // Line is high again at mid start bit: a glitch, not a byte.
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d          = '0;
          shift_d[idx_q] = rx_s;
          if (idx_q == 3'd7) begin
            state_d = ST_STOP;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
          if (rx_s) begin
            valid_o = 1'b1;
          end else begin
            stop_err_o = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign data_o = shift_q;
  assign idle_o = (state_q == ST_IDLE);

endmodule

// File: rtl/frame_rx.sv
// -----------------------------------------------------------------------------
// frame_rx
// Serial frame receiver: UART bytes are written into a frame buffer at an
// auto-incrementing address; frame completion, stop-bit errors and inter-byte
// timeouts are flagged with one-cycle pulses.
// Ports:
//   Clk           : system clock
//   i_Rst_n       : asynchronous active-low reset
//   i_RX          : asynchronous serial input, idle high
//   o_Wr_En       : one-cycle buffer write strobe
//   o_Wr_Addr     : write address (held until the next write)
//   o_Wr_Data     : write data (held until the next write)
//   o_Frame_Done  : pulses with the write of the last byte of a frame
//   o_Frame_Error : pulses when a stop bit samples low
//   o_Frame_Abort : pulses when the mid-frame idle timeout fires
//   o_Busy        : bit FSM is not in IDLE
// -----------------------------------------------------------------------------
module frame_rx
  import frame_rx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT    = DEF_CLKS_PER_BIT,
  parameter int unsigned BYTES_PER_FRAME = DEF_BYTES_PER_FRAME,
  parameter int unsigned ADDR_W          = 15,
  parameter int unsigned IDLE_TIMEOUT    = DEF_IDLE_TIMEOUT
) (
  input  logic              Clk,
  input  logic              i_Rst_n,
  input  logic              i_RX,
  output logic              o_Wr_En,
  output logic [ADDR_W-1:0] o_Wr_Addr,
  output logic [7:0]        o_Wr_Data,
  output logic              o_Frame_Done,
  output logic              o_Frame_Error,
  output logic              o_Frame_Abort,
  output logic              o_Busy
);

  localparam int unsigned TO_W = $clog2(IDLE_TIMEOUT) + 1;
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(IDLE_TIMEOUT - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(BYTES_PER_FRAME - 1);

  logic       rx_start;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_stop_err;
  logic       rx_idle;

  uart_rx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk_i     (Clk),
    .rst_ni    (i_Rst_n),
    .rx_i      (i_RX),
    .start_o   (rx_start),
    .valid_o   (rx_valid),
    .data_o    (rx_data),
    .stop_err_o(rx_stop_err),
    .idle_o    (rx_idle)
  );

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]        wr_data_q, wr_data_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              abort_q, abort_d;

  always_ff @(posedge Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      addr_q    <= '0;
      to_cnt_q  <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      abort_q   <= 1'b0;
    end else begin
      addr_q    <= addr_d;
      to_cnt_q  <= to_cnt_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      done_q    <= done_d;
      err_q     <= err_d;
      abort_q   <= abort_d;
    end
  end

  always_comb begin
    addr_d    = addr_q;
    to_cnt_d  = to_cnt_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    done_d    = 1'b0;
    err_d     = rx_stop_err;
    abort_d   = 1'b0;

    if (rx_valid) begin
      wr_en_d   = 1'b1;
      wr_addr_d = addr_q;
      wr_data_d = rx_data;
      if (addr_q == LAST_ADDR) begin
        done_d = 1'b1;
        addr_d = '0;
      end else begin
        addr_d = addr_q + ADDR_W'(1);
      end
    end

    // Timeout only counts between bytes of a partially received frame. A
    // start edge in the expiry cycle leaves IDLE, so the edge wins.
    if (!rx_idle || rx_start || (addr_q == '0)) begin
      to_cnt_d = '0;
    end else if (to_cnt_q == TO_LAST) begin
      abort_d  = 1'b1;
      addr_d   = '0;
      to_cnt_d = '0;
    end else begin
      to_cnt_d = to_cnt_q + TO_W'(1);
    end
  end

  assign o_Wr_En       = wr_en_q;
  assign o_Wr_Addr     = wr_addr_q;
  assign o_Wr_Data     = wr_data_q;
  assign o_Frame_Done  = done_q;
  assign o_Frame_Error = err_q;
  assign o_Frame_Abort = abort_q;
  assign o_Busy        = !rx_idle;

endmodule

// File: tb/tb_frame_rx.sv
// -----------------------------------------------------------------------------
// tb_frame_rx
// Directed bench for frame_rx with a write scoreboard. Uses a short bit time
// (CLKS_PER_BIT=101), a 4-byte frame and a 5000-cycle idle timeout so the
// whole sequence stays short; the glitch pulse is scaled to stay below half
// a bit time.
// -----------------------------------------------------------------------------
module tb_frame_rx;

  localparam int CLKS = 101;
  localparam int BPF  = 4;
  localparam int AW   = 15;
  localparam int TO   = 5000;
  // rx_s falling edge to o_Wr_En: half bit + 9 bits + IDLE->START cycle.
  localparam int LAT  = CLKS / 2 + 9 * CLKS + 1;
  localparam int SYNC = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          rx = 1'b1;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data;
  logic          done;
  logic          err;
  logic          abort;
  logic          busy;

  frame_rx #(
    .CLKS_PER_BIT   (CLKS),
    .BYTES_PER_FRAME(BPF),
    .ADDR_W         (AW),
    .IDLE_TIMEOUT   (TO)
  ) dut (
    .Clk          (clk),
    .i_Rst_n      (rst_n),
    .i_RX         (rx),
    .o_Wr_En      (wr_en),
    .o_Wr_Addr    (wr_addr),
    .o_Wr_Data    (wr_data),
    .o_Frame_Done (done),
    .o_Frame_Error(err),
    .o_Frame_Abort(abort),
    .o_Busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [7:0]    data;
    logic          done;
  } wr_t;

  wr_t exp_q[$];
  int  n_checks = 0;
  int  n_fail = 0;
  int  cyc = 0;
  int  n_writes = 0;
  int  n_err = 0;
  int  n_abort = 0;
  int  last_wr_cyc = 0;
  int  busy_from = 0;
  int  busy_to = -1;
  int  busy_lo = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic push_exp(input int a, input logic [7:0] d, input logic dn);
    wr_t e;
    e.addr = AW'(a);
    e.data = d;
    e.done = dn;
    exp_q.push_back(e);
  endtask

  // Must be called at a negedge; drives one 8N1 frame with the given stop bit.
  task automatic send_byte(input logic [7:0] d, input logic stop_bit);
    rx = 1'b0;
    repeat (CLKS) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (CLKS) @(negedge clk);
    end
    rx = stop_bit;
    repeat (CLKS) @(negedge clk);
    rx = 1'b1;
    repeat (20) @(negedge clk);
    $display("tx byte 0x%02h stop=%0d done at cycle %0d", d, stop_bit, cyc);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Output monitor: scoreboard compare on every write, event counters.
  initial forever begin
    wr_t e;
    @(negedge clk);
    if (rst_n) begin
      if (wr_en) begin
        n_writes++;
        last_wr_cyc = cyc;
        $display("write addr=%0d data=0x%02h done=%0d cycle=%0d", wr_addr, wr_data, done, cyc);
        check("write_expected", 32'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("wr_addr", 32'(wr_addr), 32'(e.addr));
          check("wr_data", 32'(wr_data), 32'(e.data));
          check("frame_done", 32'(done), 32'(e.done));
        end
      end else if (done) begin
        check("done_without_write", 32'(done), 0);
      end
      if (err) n_err++;
      if (abort) n_abort++;
      if (cyc >= busy_from && cyc <= busy_to && !busy) busy_lo++;
    end
  end

  initial begin
    int w0;
    int e0;
    int t0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_wr_en", 32'(wr_en), 0);
    check("rst_wr_addr", 32'(wr_addr), 0);
    check("rst_wr_data", 32'(wr_data), 0);
    check("rst_done", 32'(done), 0);
    check("rst_error", 32'(err), 0);
    check("rst_abort", 32'(abort), 0);
    check("rst_busy", 32'(busy), 0);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);

    // Glitch: short low pulse, FSM enters START then falls back to IDLE
    w0 = n_writes;
    e0 = n_err;
    rx = 1'b0;
    repeat (20) @(negedge clk);
    check("glitch_busy_start", 32'(busy), 1);
    rx = 1'b1;
    repeat (3 * CLKS) @(negedge clk);
    check("glitch_busy_idle", 32'(busy), 0);
    check("glitch_no_write", 32'(n_writes), 32'(w0));
    check("glitch_no_error", 32'(n_err), 32'(e0));
    $display("glitch step complete at cycle %0d", cyc);

    // Bad stop bit: error pulse, byte discarded, next byte at addr 0
    w0 = n_writes;
    send_byte(8'h3C, 1'b0);
    repeat (10) @(negedge clk);
    check("badstop_error", 32'(n_err), 32'(e0 + 1));
    check("badstop_no_write", 32'(n_writes), 32'(w0));
    push_exp(0, 8'h11, 1'b0);
    send_byte(8'h11, 1'b1);
    check("after_err_write", 32'(n_writes), 32'(w0 + 1));

    // Reset during DATA bit 4 of a byte
    w0 = n_writes;
    rx = 1'b0;
    repeat (CLKS) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx = 1'(8'h96 >> i);
      repeat (CLKS) @(negedge clk);
    end
    rx = 1'b1;
    repeat (CLKS / 2) @(negedge clk);
    check("pre_reset_busy", 32'(busy), 1);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("midrst_wr_en", 32'(wr_en), 0);
    check("midrst_wr_addr", 32'(wr_addr), 0);
    check("midrst_wr_data", 32'(wr_data), 0);
    check("midrst_done", 32'(done), 0);
    check("midrst_error", 32'(err), 0);
    check("midrst_abort", 32'(abort), 0);
    check("midrst_busy", 32'(busy), 0);
    rx = 1'b1;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("midrst_no_write", 32'(n_writes), 32'(w0));
    $display("reset step complete at cycle %0d", cyc);

    // Timeout: two bytes into the frame, then idle past IDLE_TIMEOUT
    push_exp(0, 8'h66, 1'b0);
    send_byte(8'h66, 1'b1);
    push_exp(1, 8'h5A, 1'b0);
    send_byte(8'h5A, 1'b1);
    check("pre_idle_abort", 32'(n_abort), 0);
    repeat (6000) @(negedge clk);
    check("timeout_abort_once", 32'(n_abort), 1);
    $display("timeout step complete at cycle %0d aborts=%0d", cyc, n_abort);

    // Full frame after abort restarts at addr 0; wrap at the end
    push_exp(0, 8'h01, 1'b0);
    send_byte(8'h01, 1'b1);
    push_exp(1, 8'h02, 1'b0);
    send_byte(8'h02, 1'b1);
    push_exp(2, 8'h03, 1'b0);
    send_byte(8'h03, 1'b1);
    push_exp(3, 8'h04, 1'b1);
    send_byte(8'h04, 1'b1);

    // Single byte after wrap: addr 0, latency and busy throughout
    check("idle_busy", 32'(busy), 0);
    push_exp(0, 8'hA5, 1'b0);
    t0 = cyc;
    busy_from = t0 + SYNC + 1;
    busy_to = t0 + SYNC + LAT - 1;
    send_byte(8'hA5, 1'b1);
    check("latency", 32'(last_wr_cyc - t0 - SYNC), 32'(LAT));
    check("busy_throughout", 32'(busy_lo), 0);
    busy_to = -1;

    repeat (50) @(negedge clk);
    check("sb_empty", 32'(exp_q.size()), 0);
    check("total_writes", 32'(n_writes), 8);
    check("total_errors", 32'(n_err), 1);
    check("total_aborts", 32'(n_abort), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
